// File: rtl/mem_responder_if.sv
// Datapath <-> memory responder handshake: request, address/data, and completion status.
interface mem_responder_if;
  logic        Read;
  logic        Write;
  logic [31:0] MARaddr;
  logic [31:0] MDRdata;
  logic [31:0] Mdatain;
  logic        Done;
  logic        Busy;
  logic        Err;

  modport slave  (input  Read, Write, MARaddr, MDRdata,
                  output Mdatain, Done, Busy, Err);
  modport master (output Read, Write, MARaddr, MDRdata,
                  input  Mdatain, Done, Busy, Err);
endinterface

// File: rtl/mem_responder.sv
// Single-port 32-bit memory behind a Read/Write request handshake with a fixed,
// parameterised wait before each access and a registered read-data output.
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_BITS   = 9
) (
  input  logic            clock,
  input  logic            clear,
  mem_responder_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE, RELEASE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);
  localparam int         DEPTH    = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [31:0]            data_q, data_d;
  logic [31:0]            rdata_q;
  logic                   err_q, err_d;
  logic                   acc_wr, acc_rd;

  // Upper MAR bits alias onto the decoded range.
  logic unused_addr;
  assign unused_addr = ^bus.MARaddr[31:ADDR_BITS];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = 1'b0;
    acc_wr  = 1'b0;
    acc_rd  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.Read ^ bus.Write) begin
          op_wr_d = bus.Write;
          addr_d  = bus.MARaddr[ADDR_BITS-1:0];
          data_d  = bus.MDRdata;
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end else if (bus.Read && bus.Write) begin
          err_d   = 1'b1;
          state_d = RELEASE;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          acc_wr  = op_wr_q;
          acc_rd  = !op_wr_q;
          state_d = DONE;
        end
      end
      DONE:    state_d = (bus.Read || bus.Write) ? RELEASE : IDLE;
      RELEASE: if (!bus.Read && !bus.Write) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
      if (acc_rd) rdata_q <= mem[addr_q];
    end
  end

  // Storage is never reset; clear only suppresses an access on its own edge.
  always_ff @(posedge clock) begin
    if (!clear && acc_wr) mem[addr_q] <= data_q;
  end

  assign bus.Mdatain = rdata_q;
  assign bus.Done    = (state_q == DONE);
  assign bus.Busy    = (state_q != IDLE);
  assign bus.Err     = err_q;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the number of wait cycles inserted between request capture and the memory access (range 0..15).
REQ-002 The block SHALL have parameter ADDR_BITS, default 9, meaning the number of low MAR bits decoded; memory depth is 2^ADDR_BITS words of 32 bits.
REQ-003 clock  input  1  single clock; all state changes on the rising edge.
REQ-004 clear  input  1  reset, synchronous, active-high.
REQ-005 Read  input  1  read request from the datapath; held high until Done is seen.
REQ-006 Write  input  1  write request from the datapath; held high until Done is seen.
REQ-007 MARaddr  input  32  address from the datapath MAR; only bits [ADDR_BITS-1:0] are used.
REQ-008 MDRdata  input  32  write data from the datapath MDR.
REQ-009 Mdatain  output  32  read data returned to the datapath MDR input.
REQ-010 Done  output  1  one-cycle completion pulse.
REQ-011 Busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 Err  output  1  one-cycle pulse flagging an illegal request (Read and Write both high).

Function
REQ-013 The FSM SHALL have exactly the states IDLE, WAIT, DONE and RELEASE.
REQ-014 IDLE, exactly one of Read/Write high at an edge: latch op, MARaddr[ADDR_BITS-1:0] and MDRdata, load cnt with WAIT_CYCLES, go to WAIT.
REQ-015 IDLE, Read and Write both high at an edge: no latch, no access, Err high for the next cycle, go to RELEASE.
REQ-016 IDLE, neither request high: remain in IDLE.
REQ-017 WAIT, cnt nonzero: decrement cnt and stay in WAIT.
REQ-018 WAIT, cnt zero: perform the access on that edge (write the latched data to mem[latched addr], or load Mdatain from mem[latched addr]), then go to DONE.
REQ-019 Done SHALL be high only in DONE; the first Done-high cycle follows edge E0+WAIT_CYCLES+1, where E0 is the capture edge (Done after edge 3 for the default).
REQ-020 DONE SHALL go to RELEASE if Read or Write is still high at the next edge, else to IDLE; Done lasts exactly one cycle in either case.
REQ-021 RELEASE SHALL go to IDLE on the first edge at which Read and Write are both low; a request still held is never re-serviced.
REQ-022 Mdatain SHALL change only on read accesses and SHALL hold the last read value otherwise, including across writes to the same address.
REQ-023 Inputs changed after the capture edge SHALL NOT affect the in-flight access.
REQ-024 Address bits above ADDR_BITS-1 SHALL be ignored, so addresses alias modulo 2^ADDR_BITS with no error.
REQ-025 Memory reads SHALL be synchronous (registered into Mdatain); no combinational path from inputs to any output.

Reset
REQ-026 With clear high at an edge: state becomes IDLE, cnt 0, Mdatain 0x00000000, and Done, Busy and Err all 0.
REQ-027 clear SHALL take priority over every FSM transition, including in the same edge as a capture or an access.
REQ-028 clear during WAIT SHALL abort the operation, and a write aborted before its access edge SHALL leave memory unmodified.
REQ-029 Memory contents SHALL NOT be cleared by clear.
REQ-030 Requests still high after clear deasserts SHALL be treated as new requests from IDLE.

Verification
REQ-031 Write then read: Write, MARaddr=0x00000010, MDRdata=0xDEADBEEF; after Done, drop Write, then Read at 0x10 -> Done after edge 3 and Mdatain=0xDEADBEEF.
REQ-032 Latency sweep: WAIT_CYCLES=0 and 5 -> Done first high after edges 1 and 6 respectively, Busy high from edge 1 until return to IDLE.
REQ-033 Both requests high in IDLE -> Err pulses for one cycle, no Done, memory and Mdatain unchanged, IDLE reached only after both requests drop.
REQ-034 Write of 0x12345678 to 0x20 with clear asserted at edge 2 (in WAIT) -> a later read of 0x20 returns the prior contents and all outputs are 0 after the clear edge.
REQ-035 Aliasing: write 0xA5A5A5A5 to 0x00000205, read 0x00000005 (ADDR_BITS=9) -> Mdatain=0xA5A5A5A5, Err stays 0.
REQ-036 Read held high 10 cycles past Done -> exactly one Done pulse and Busy high until Read drops.
